// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous dmem. Grant is combinational and read data returns one cycle later.
// A requester holds req until it sees gnt. The optional bounded lock is capped by MAX_HOLD. Optional counters are enabled by DMEM_ARB_STATS_EN.
module dmem_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic              a_lock,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic              b_lock,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] address_dmem,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  input  logic [DATA_W-1:0] q_dmem
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_a_gnts,
  output logic [15:0]       stat_b_gnts,
  output logic [15:0]       stat_conflicts
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_OWN_A, S_OWN_B} state_t;

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);
  localparam logic       PTR_A    = 1'b0;
  localparam logic       PTR_B    = 1'b1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_ptr;
  logic                w_ptr_nxt;
  logic [7:0]          r_hold_cnt;
  logic [7:0]          w_hold_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_a_rvalid;
  logic                r_b_rvalid;
  logic                r_rd_tag;
  logic                w_gnt_a;
  logic                w_gnt_b;
  logic                w_idle_arb;

  always_comb begin
    w_gnt_a     = 1'b0;
    w_gnt_b     = 1'b0;
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold_cnt;
    w_idle_arb  = 1'b0;

    case (r_state)
      S_IDLE: w_idle_arb = 1'b1;
      S_OWN_A: begin
        if (!a_req) begin
          w_idle_arb = 1'b1;
        end else if (r_hold_cnt >= HOLD_MAX && b_req) begin
          w_gnt_b     = 1'b1;
          w_ptr_nxt   = PTR_A;
          w_hold_nxt  = 8'd1;
          w_state_nxt = b_lock ? S_OWN_B : S_IDLE;
        end else begin
          w_gnt_a     = 1'b1;
          w_hold_nxt  = b_req ? r_hold_cnt + 8'd1 : 8'd1;
          w_state_nxt = a_lock ? S_OWN_A : S_IDLE;
        end
      end
      S_OWN_B: begin
        if (!b_req) begin
          w_idle_arb = 1'b1;
        end else if (r_hold_cnt >= HOLD_MAX && a_req) begin
          w_gnt_a     = 1'b1;
          w_ptr_nxt   = PTR_B;
          w_hold_nxt  = 8'd1;
          w_state_nxt = a_lock ? S_OWN_A : S_IDLE;
        end else begin
          w_gnt_b     = 1'b1;
          w_hold_nxt  = a_req ? r_hold_cnt + 8'd1 : 8'd1;
          w_state_nxt = b_lock ? S_OWN_B : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // An owner that dropped req falls back to plain IDLE arbitration in the same cycle.
    if (w_idle_arb) begin
      w_state_nxt = S_IDLE;
      if (a_req && b_req) begin
        w_gnt_a   = (r_ptr == PTR_A);
        w_gnt_b   = (r_ptr == PTR_B);
        w_ptr_nxt = ~r_ptr;
      end else begin
        w_gnt_a = a_req;
        w_gnt_b = b_req;
      end
      if (w_gnt_a && a_lock) begin
        w_state_nxt = S_OWN_A;
        w_hold_nxt  = 8'd1;
      end else if (w_gnt_b && b_lock) begin
        w_state_nxt = S_OWN_B;
        w_hold_nxt  = 8'd1;
      end
    end

    if (reset) begin
      w_gnt_a = 1'b0;
      w_gnt_b = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ptr      <= PTR_A;
      r_hold_cnt <= 8'd0;
      r_addr     <= '0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_rd_tag   <= PTR_A;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_addr     <= address_dmem;
      r_a_rvalid <= w_gnt_a & ~a_we;
      r_b_rvalid <= w_gnt_b & ~b_we;
      if (w_gnt_a && !a_we) r_rd_tag <= PTR_A;
      else if (w_gnt_b && !b_we) r_rd_tag <= PTR_B;
    end
  end

  assign a_gnt = w_gnt_a;
  assign b_gnt = w_gnt_b;
  assign wren  = (w_gnt_a & a_we) | (w_gnt_b & b_we);
  assign data  = w_gnt_a ? a_wdata : (w_gnt_b ? b_wdata : '0);

  always_comb begin
    address_dmem = r_addr;
    if (reset) address_dmem = '0;
    else if (w_gnt_a) address_dmem = a_addr;
    else if (w_gnt_b) address_dmem = b_addr;
  end

  // q_dmem is passed straight through to whichever port issued the last read.
  assign a_rvalid = r_a_rvalid & ~reset;
  assign b_rvalid = r_b_rvalid & ~reset;
  assign a_rdata  = (r_rd_tag == PTR_A) ? q_dmem : '0;
  assign b_rdata  = (r_rd_tag == PTR_B) ? q_dmem : '0;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] r_stat_a;
  logic [15:0] r_stat_b;
  logic [15:0] r_stat_c;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stat_a <= 16'd0;
      r_stat_b <= 16'd0;
      r_stat_c <= 16'd0;
    end else begin
      if (w_gnt_a && r_stat_a != 16'hFFFF) r_stat_a <= r_stat_a + 16'd1;
      if (w_gnt_b && r_stat_b != 16'hFFFF) r_stat_b <= r_stat_b + 16'd1;
      if (a_req && b_req && r_stat_c != 16'hFFFF) r_stat_c <= r_stat_c + 16'd1;
    end
  end

  assign stat_a_gnts    = r_stat_a;
  assign stat_b_gnts    = r_stat_b;
  assign stat_conflicts = r_stat_c;
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port synchronous dmem between two requesters.
- Port A is the processor load/store path. Port B is a debug/DMA master, e.g. a program loader or a memory inspector.
- Per-cycle round-robin arbitration, with an optional bounded lock for back-to-back bursts.
- Sits between the requesters and the dmem address/data/wren/q pins, on the same clock that drives the dmem.

Parameters:
- ADDR_W, 12, dmem word-address width.
- DATA_W, 32, dmem data width.
- MAX_HOLD, 8, maximum consecutive grants to a locked owner while the other port is requesting (range 1..255).

Ports:
- clock  in  1  dmem/arbiter clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- a_req  in  1  port A access request; held until granted.
- a_we  in  1  port A write enable (1 = write, 0 = read).
- a_lock  in  1  port A requests continued ownership after this grant.
- a_addr  in  ADDR_W  port A word address.
- a_wdata  in  DATA_W  port A write data.
- a_gnt  out  1  port A access accepted this cycle.
- a_rvalid  out  1  port A read data valid; one cycle after a read grant.
- a_rdata  out  DATA_W  port A read data.
- b_req, b_we, b_lock, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as port A, for port B.
- address_dmem  out  ADDR_W  to dmem address.
- data  out  DATA_W  to dmem write data.
- wren  out  1  to dmem write enable.
- q_dmem  in  DATA_W  from dmem; valid the cycle after the address is presented.

Behaviour:
- Reset:
  - reset=1 forces a_gnt, b_gnt, wren, a_rvalid and b_rvalid to 0.
  - address_dmem and data are forced to 0.
  - FSM enters IDLE, the round-robin pointer is set to favour A, and hold_cnt is set to 0.
  - Reset asserted mid-burst drops ownership immediately. A read granted in the reset cycle produces no rvalid.
- Grant decision:
  - Combinational from req, FSM state and pointer; at most one gnt per cycle.
  - gnt=1 means the dmem is driven that cycle from the granted port's addr, wdata and we. wren = we & gnt.
  - A requester must hold req and its fields stable until it sees gnt.
- No grant: address_dmem holds its last value, wren=0, data=0.
- FSM states: IDLE, OWN_A, OWN_B.
- IDLE:
  - Only one req asserted: that port is granted.
  - Both asserted: the pointer's port is granted, and the pointer flips to the other port.
  - Granted port has lock=1: go to OWN_x with hold_cnt=1.
- OWN_x:
  - x_req=1 and hold_cnt < MAX_HOLD: x is granted; hold_cnt increments while the other port requests, otherwise it resets to 1.
  - x_lock=0 on a grant: return to IDLE after that grant.
  - x_req=0: return to IDLE with no grant to x that cycle. The other port may be granted in the same cycle under IDLE rules.
  - hold_cnt = MAX_HOLD and the other port is requesting: lock is forcibly broken, the other port is granted, the pointer is set to favour x, and the next state is IDLE or OWN_other per the new owner's lock.
- Read return:
  - A read grant in cycle N gives x_rvalid=1 in cycle N+1, with x_rdata = q_dmem (pass-through).
  - A registered "last reader" tag steers rdata; the non-tagged port's rdata is 0.
- Writes: no rvalid; write completes at the grant edge.
- Read-after-write to the same address, either port: the second access sees the new data, because the dmem write lands at the grant edge.
- Throughput: one access per cycle sustained. No bubble between ports on switch.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined:
  - Adds outputs stat_a_gnts[15:0], stat_b_gnts[15:0] and stat_conflicts[15:0].
  - The counters count grants per port and cycles where both req=1.
  - Counters saturate at 16'hFFFF and are cleared by reset.
- When undefined: these ports and counters do not exist. Arbitration behaviour is identical in both builds.

Test Plan:
- Only a_req=1 (read, addr 0x010, memory holds 0xDEADBEEF) -> a_gnt=1 same cycle; next cycle a_rvalid=1 and a_rdata=0xDEADBEEF; b_rvalid=0.
- Both req=1 every cycle, lock=0, from reset -> grants alternate A,B,A,B; stat_conflicts counts 4 after 4 cycles (stats build).
- B writes 0x12345678 to 0x020 with lock=1 for 3 cycles while A idles -> three consecutive b_gnt; wren=1 each cycle; FSM returns to IDLE when b_lock drops.
- B locked and A requesting continuously, MAX_HOLD=8 -> exactly 8 b_gnt, then a_gnt on cycle 9; the pointer then favours B.
- B write to 0x030 in cycle N, A read of 0x030 in cycle N+1 -> a_rdata equals B's data in cycle N+2.
- Reset asserted during OWN_B with a read in flight -> all gnt, rvalid and wren are 0 the next cycle; the first post-reset conflict grants A.
